// File: rtl/bitfusion_pe.sv
// bitfusion_pe: bit-fusion MAC element with lane-split dot product.
// Three-stage pipe (capture, dot, accumulate) with valid/ready on both sides.
module bitfusion_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] weight,
  input  logic [1:0]        prec,
  input  logic              s_in,
  input  logic              s_weight,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  psum,
  output logic [CNT_W-1:0]  count
);

  localparam int L4 = DATA_W / 4;
  localparam int L2 = DATA_W / 2;
  localparam int PW = 2 * DATA_W + 2;

  logic              stall;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_in;
  logic [DATA_W-1:0] s1_wt;
  logic [1:0]        s1_prec;
  logic              s1_sa;
  logic              s1_sw;
  logic              s1_last;

  logic              d_valid;
  logic [ACC_W-1:0]  d_dot;
  logic              d_last;

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  gcnt;
  logic              first;

  logic [ACC_W-1:0]  dot;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_nxt;

  logic [PW-1:0]     af;
  logic [PW-1:0]     bf;
  logic [PW-1:0]     pf;
  logic [9:0]        a4;
  logic [9:0]        b4;
  logic [9:0]        p4;
  logic [5:0]        a2;
  logic [5:0]        b2;
  logic [5:0]        p2;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = rst_n & ~stall;

  // Capture stage: latch the offered element when accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_in    <= '0;
      s1_wt    <= '0;
      s1_prec  <= '0;
      s1_sa    <= 1'b0;
      s1_sw    <= 1'b0;
      s1_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_in   <= in;
        s1_wt   <= weight;
        s1_prec <= prec;
        s1_sa   <= s_in;
        s1_sw   <= s_weight;
        s1_last <= in_last;
      end
    end
  end

  // Lane split, per-lane extend and multiply, reduce to one dot value.
  always_comb begin
    dot = '0;
    af  = '0;
    bf  = '0;
    pf  = '0;
    a4  = '0;
    b4  = '0;
    p4  = '0;
    a2  = '0;
    b2  = '0;
    p2  = '0;
    unique case (1'b1)
      s1_prec == 2'b01: begin
        for (int k = 0; k < L4; k++) begin
          a4  = {{6{s1_sa & s1_in[4*k+3]}}, s1_in[4*k +: 4]};
          b4  = {{6{s1_sw & s1_wt[4*k+3]}}, s1_wt[4*k +: 4]};
          p4  = a4 * b4;
          dot = dot + {{(ACC_W-10){p4[9]}}, p4};
        end
      end
      s1_prec == 2'b10: begin
        for (int k = 0; k < L2; k++) begin
          a2  = {{4{s1_sa & s1_in[2*k+1]}}, s1_in[2*k +: 2]};
          b2  = {{4{s1_sw & s1_wt[2*k+1]}}, s1_wt[2*k +: 2]};
          p2  = a2 * b2;
          dot = dot + {{(ACC_W-6){p2[5]}}, p2};
        end
      end
      default: begin
        af  = {{(PW-DATA_W){s1_sa & s1_in[DATA_W-1]}}, s1_in};
        bf  = {{(PW-DATA_W){s1_sw & s1_wt[DATA_W-1]}}, s1_wt};
        pf  = af * bf;
        dot = {{(ACC_W-PW){pf[PW-1]}}, pf};
      end
    endcase
  end

  // Dot stage: register the reduced product with its last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_dot   <= '0;
      d_last  <= 1'b0;
    end else if (!stall) begin
      d_valid <= s1_valid;
      if (s1_valid) begin
        d_dot  <= dot;
        d_last <= s1_last;
      end
    end
  end

  assign sum     = (first ? '0 : acc) + d_dot;
  assign cnt_nxt = first ? CNT_W'(1)
                 : (&gcnt ? gcnt : gcnt + CNT_W'(1));

  // Accumulate stage: fold into the group, publish on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      gcnt      <= '0;
      first     <= 1'b1;
      psum      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (d_valid && d_last) begin
        psum      <= sum;
        count     <= cnt_nxt;
        out_valid <= 1'b1;
        first     <= 1'b1;
        acc       <= '0;
        gcnt      <= '0;
      end else begin
        out_valid <= 1'b0;
        if (d_valid) begin
          acc   <= sum;
          gcnt  <= cnt_nxt;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitfusion_pe.sv
// tb_bitfusion_pe: vector table plus scoreboard bench for bitfusion_pe.
// Expected group results are queued at acceptance and popped on output.
module tb_bitfusion_pe;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int CW = 8;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_d = '0;
  logic [DW-1:0] wt_d = '0;
  logic [1:0]    prec_d = '0;
  logic          s_in_d = 1'b0;
  logic          s_w_d = 1'b0;
  logic          last_d = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] psum;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  bitfusion_pe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_d),
    .weight   (wt_d),
    .prec     (prec_d),
    .s_in     (s_in_d),
    .s_weight (s_w_d),
    .in_last  (last_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .psum     (psum),
    .count    (count)
  );

  typedef struct {
    logic [AW-1:0] psum;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0]    a;
    logic [7:0]    w;
    logic [1:0]    p;
    bit            sa;
    bit            sw;
    bit            lst;
    logic [AW-1:0] ep;
    logic [CW-1:0] ec;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[NV];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [AW-1:0] m_acc = '0;
  int            m_cnt = 0;
  bit            rnd_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic int sx(input int v, input int lw, input bit s);
    if (s && v >= (1 << (lw - 1))) return v - (1 << lw);
    return v;
  endfunction

  function automatic int model_dot(input logic [7:0] a,
                                   input logic [7:0] w,
                                   input logic [1:0] p,
                                   input bit sa, input bit sw);
    int lw;
    int m;
    int r;
    lw = (p == 2'b01) ? 4 : ((p == 2'b10) ? 2 : 8);
    m  = (1 << lw) - 1;
    r  = 0;
    for (int k = 0; k < 8 / lw; k++)
      r += sx((int'(a) >> (k * lw)) & m, lw, sa)
         * sx((int'(w) >> (k * lw)) & m, lw, sw);
    return r;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] w,
                      input logic [1:0] p, input bit sa, input bit sw,
                      input bit lst, input bit fixed,
                      input logic [AW-1:0] ep, input logic [CW-1:0] ec,
                      output int waits);
    exp_t e;
    waits    = 0;
    in_d     = a;
    wt_d     = w;
    prec_d   = p;
    s_in_d   = sa;
    s_w_d    = sw;
    last_d   = lst;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    m_acc = m_acc + AW'(model_dot(a, w, p, sa, sw));
    if (m_cnt < 255) m_cnt++;
    if (lst) begin
      e.psum = fixed ? ep : m_acc;
      e.cnt  = fixed ? ec : CW'(m_cnt);
      sb.push_back(e);
      m_acc = '0;
      m_cnt = 0;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ov(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic main_seq();
    int w;
    int tot;
    bit ok;
    tbl[0] = '{8'hFF, 8'h03, 2'b00, 1, 1, 1, 20'hFFFFD, 8'd1};
    tbl[1] = '{8'h21, 8'h34, 2'b01, 0, 0, 0, 20'h0, 8'd0};
    tbl[2] = '{8'hFF, 8'h11, 2'b01, 0, 0, 1, 20'd40, 8'd2};
    tbl[3] = '{8'hFF, 8'hE4, 2'b10, 1, 0, 1, 20'hFFFFA, 8'd1};
    tbl[4] = '{8'h10, 8'h10, 2'b11, 0, 0, 1, 20'd256, 8'd1};
    tbl[5] = '{8'h8F, 8'h7F, 2'b01, 1, 1, 1, 20'hFFFC9, 8'd1};
    tbl[6] = '{8'hFF, 8'hFF, 2'b00, 0, 0, 1, 20'h0FE01, 8'd1};
    tbl[7] = '{8'h80, 8'hFF, 2'b00, 1, 0, 1, 20'hF8080, 8'd1};
    tbl[8] = '{8'hFF, 8'hFF, 2'b10, 0, 0, 0, 20'h0, 8'd0};
    tbl[9] = '{8'h80, 8'h80, 2'b00, 1, 1, 1, 20'h04024, 8'd2};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_psum", psum, 0);
    chk("rst_count", count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    idle(1);

    tot = 0;
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].a, tbl[i].w, tbl[i].p, tbl[i].sa, tbl[i].sw,
           tbl[i].lst, 1'b1, tbl[i].ep, tbl[i].ec, w);
      tot += w;
    end
    chk("back_to_back_waits", tot, 0);
    idle(4);

    send(8'hFF, 8'h03, 2'b00, 1, 1, 1, 1'b0, '0, '0, w);
    @(negedge clk);
    @(negedge clk);
    chk("latency_t1", out_valid, 0);
    @(negedge clk);
    chk("latency_t2", out_valid, 1);
    idle(3);

    @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      begin
        send(8'd3, 8'd5, 2'b00, 0, 0, 1, 1'b0, '0, '0, w);
        send(8'h12, 8'h34, 2'b01, 0, 1, 0, 1'b0, '0, '0, w);
        send(8'hC7, 8'h9A, 2'b10, 1, 1, 0, 1'b0, '0, '0, w);
        send(8'h85, 8'h7E, 2'b00, 1, 1, 1, 1'b0, '0, '0, w);
        send(8'h44, 8'h21, 2'b00, 0, 0, 0, 1'b0, '0, '0, w);
        send(8'hF0, 8'h0F, 2'b01, 1, 0, 1, 1'b0, '0, '0, w);
      end
      begin
        wait_ov(ok);
        chk("stall_ov_seen", ok, 1);
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_in_valid", in_valid, 1);
          if (sb.size() > 0) begin
            chk("stall_psum", psum, sb[0].psum);
            chk("stall_count", count, sb[0].cnt);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);

    send(8'd1, 8'd1, 2'b00, 0, 0, 0, 1'b0, '0, '0, w);
    send(8'd2, 8'd2, 2'b00, 0, 0, 0, 1'b0, '0, '0, w);
    rst_n = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", in_ready, 1);
    idle(1);
    send(8'h02, 8'h03, 2'b00, 0, 0, 1, 1'b1, 20'd6, 8'd1, w);
    idle(4);

    rnd_en = 1'b1;
    for (int g = 0; g < 25; g++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int e = 0; e < len; e++)
        send(8'($urandom), 8'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), e == len - 1,
             1'b0, '0, '0, w);
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    for (int i = 0; i < 300; i++)
      send(8'd1, 8'd1, 2'b00, 0, 0, i == 299, 1'b0, '0, '0, w);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    fork
      main_seq();
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          chk("output_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("psum", psum, e.psum);
            chk("count", count, e.cnt);
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
